// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with M/W operand forwarding, load-use stall detection
// and bubble insertion on load-use or taken-branch flush.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int ALUC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic              reg_write_d,
  input  logic              mem_read_d,
  input  logic              mem_write_d,
  input  logic              alu_src_d,
  input  logic [ALUC_W-1:0] alu_ctrl_d,
  input  logic              flush_e,
  input  logic [4:0]        rd_m,
  input  logic              reg_write_m,
  input  logic [XLEN-1:0]   alu_result_m,
  input  logic [4:0]        rd_w,
  input  logic              reg_write_w,
  input  logic [XLEN-1:0]   result_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              valid_e,
  output logic              reg_write_e,
  output logic              mem_read_e,
  output logic              mem_write_e,
  output logic              alu_src_e,
  output logic [ALUC_W-1:0] alu_ctrl_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   src_a_e,
  output logic [XLEN-1:0]   src_b_e,
  output logic [XLEN-1:0]   write_data_e
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [ALUC_W-1:0] alu_ctrl;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
  } e_regs_t;

  e_regs_t    e_q, e_d;
  logic       lu_s;
  logic [XLEN-1:0] fwd_a_s, fwd_b_s;

  // M has the younger result, so it is checked first; x0 is never bypassed.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      src,
    input logic [XLEN-1:0] base,
    input logic            we_m, input logic [4:0] dst_m, input logic [XLEN-1:0] val_m,
    input logic            we_w, input logic [4:0] dst_w, input logic [XLEN-1:0] val_w
  );
    logic [XLEN-1:0] r;
    if (we_m && (dst_m != 5'd0) && (dst_m == src)) begin
      r = val_m;
    end else if (we_w && (dst_w != 5'd0) && (dst_w == src)) begin
      r = val_w;
    end else begin
      r = base;
    end
    return r;
  endfunction

  assign lu_s = e_q.valid & e_q.mem_read & (e_q.rd != 5'd0) & valid_d &
                ((e_q.rd == rs1_d) | (e_q.rd == rs2_d));

  // A flush kills the D instruction, so stalling it would be pointless.
  assign stall_f = lu_s & ~flush_e;
  assign stall_d = lu_s & ~flush_e;

  always_comb begin
    e_d = '0;
    if (flush_e || lu_s) begin
      e_d = '0;
    end else begin
      e_d.valid     = valid_d;
      e_d.reg_write = reg_write_d & valid_d;
      e_d.mem_read  = mem_read_d  & valid_d;
      e_d.mem_write = mem_write_d & valid_d;
      e_d.alu_src   = alu_src_d   & valid_d;
      e_d.alu_ctrl  = alu_ctrl_d;
      e_d.rs1       = rs1_d;
      e_d.rs2       = rs2_d;
      e_d.rd        = rd_d;
      e_d.rd1       = rd1_d;
      e_d.rd2       = rd2_d;
      e_d.imm       = imm_d;
      e_d.pc        = pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  always_comb begin
    fwd_a_s = fwd_sel(e_q.rs1, e_q.rd1, reg_write_m, rd_m, alu_result_m,
                      reg_write_w, rd_w, result_w);
    fwd_b_s = fwd_sel(e_q.rs2, e_q.rd2, reg_write_m, rd_m, alu_result_m,
                      reg_write_w, rd_w, result_w);
  end

  assign valid_e      = e_q.valid;
  assign reg_write_e  = e_q.reg_write;
  assign mem_read_e   = e_q.mem_read;
  assign mem_write_e  = e_q.mem_write;
  assign alu_src_e    = e_q.alu_src;
  assign alu_ctrl_e   = e_q.alu_ctrl;
  assign rs1_e        = e_q.rs1;
  assign rs2_e        = e_q.rs2;
  assign rd_e         = e_q.rd;
  assign imm_e        = e_q.imm;
  assign pc_e         = e_q.pc;
  assign src_a_e      = fwd_a_s;
  assign src_b_e      = e_q.alu_src ? e_q.imm : fwd_b_s;
  assign write_data_e = fwd_b_s;

endmodule
